// File: rtl/sdr_init_cmd_monitor.sv
// sdr_init_cmd_monitor
// Passive monitor on the SDRAM command pins. It decodes every sampled cycle
// into a command, follows the power-up initialisation sequence
// (NOP window, precharge-all, auto-refreshes, mode-register set), enforces
// the tRP/tRFC/tMRD minimum gaps and reports progress plus the first
// violation seen. Nothing here drives the SDRAM bus.
module sdr_init_cmd_monitor #(
    parameter int SDR_AW          = 13,
    parameter int SDR_BW          = 2,
    parameter int INIT_NOP_CYCLES = 8,
    parameter int TRP             = 3,
    parameter int TRFC            = 7,
    parameter int TMRD            = 2,
    parameter int N_REFRESH       = 2
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [SDR_AW-1:0] sdr_addr,
    input  logic [SDR_BW-1:0] sdr_ba,
    output logic [2:0]        cmd_o,
    output logic              cmd_vld_o,
    output logic [2:0]        init_state_o,
    output logic              init_done_o,
    output logic              init_err_o,
    output logic [2:0]        err_code_o,
    output logic [3:0]        ref_cnt_o,
    output logic [SDR_AW-1:0] mode_reg_o
);

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_WAIT_PRE = 3'd1,
        ST_REFRESH  = 3'd2,
        ST_WAIT_MRS = 3'd3,
        ST_MRD      = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd7
    } init_state_t;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_READ = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_AREF = 3'd5;
    localparam logic [2:0] CMD_MRS  = 3'd6;
    localparam logic [2:0] CMD_BST  = 3'd7;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_EARLY = 3'd1;
    localparam logic [2:0] ERR_PRE   = 3'd2;
    localparam logic [2:0] ERR_TRP   = 3'd3;
    localparam logic [2:0] ERR_TRFC  = 3'd4;
    localparam logic [2:0] ERR_ORDER = 3'd5;
    localparam logic [2:0] ERR_TMRD  = 3'd6;

    // Gap timer holds "cycles still forbidden"; loading T-1 makes a command
    // exactly T cycles after the arming command the first legal one.
    localparam int               TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TRP_LD   = (TRP  > 1) ? TMR_W'(TRP  - 1) : TMR_ZERO;
    localparam logic [TMR_W-1:0] TRFC_LD  = (TRFC > 1) ? TMR_W'(TRFC - 1) : TMR_ZERO;
    localparam logic [TMR_W-1:0] TMRD_LD  = (TMRD > 1) ? TMR_W'(TMRD - 1) : TMR_ZERO;
    localparam bit               MRD_SKIP = (TMRD <= 1);

    localparam logic [15:0] INIT_NOP_LIM = 16'(INIT_NOP_CYCLES);
    localparam logic [3:0]  N_REF_LIM    = 4'(N_REFRESH);

    // Saturating increment for the 16-bit NOP window counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Saturating increment for the 4-bit refresh counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val);
        return (val == 4'hF) ? val : val + 4'd1;
    endfunction

    init_state_t       state_r;
    init_state_t       state_leg_s;
    init_state_t       state_nxt_s;
    logic [2:0]        cmd_s;
    logic              is_nop_s;
    logic [15:0]       nop_cnt_r;
    logic [15:0]       nop_cnt_inc_s;
    logic [3:0]        ref_cnt_inc_s;
    logic [TMR_W-1:0]  tmr_r;
    logic [2:0]        tmr_code_r;
    logic              tmr_busy_s;
    logic [2:0]        viol_s;
    logic              ref_inc_s;
    logic              mode_cap_s;
    logic              done_set_s;
    logic [2:0]        cmd_r;
    logic              cmd_vld_r;
    logic              init_done_r;
    logic              init_err_r;
    logic [2:0]        err_code_r;
    logic [3:0]        ref_cnt_r;
    logic [SDR_AW-1:0] mode_reg_r;
    logic              ba_unused_s;

    // Bank address plays no part in init tracking.
    assign ba_unused_s = ^sdr_ba;

    // Decode the sampled command pins into a command code.
    always_comb begin
        cmd_s = CMD_NOP;
        if (sdr_cs_n) begin
            cmd_s = CMD_NOP;
        end else begin
            case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
                3'b011:  cmd_s = CMD_ACT;
                3'b101:  cmd_s = CMD_READ;
                3'b100:  cmd_s = CMD_WR;
                3'b010:  cmd_s = CMD_PRE;
                3'b001:  cmd_s = CMD_AREF;
                3'b000:  cmd_s = CMD_MRS;
                3'b110:  cmd_s = CMD_BST;
                default: cmd_s = CMD_NOP;
            endcase
        end
    end

    assign is_nop_s      = (cmd_s == CMD_NOP);
    assign nop_cnt_inc_s = sat_inc16(nop_cnt_r);
    assign ref_cnt_inc_s = sat_inc4(ref_cnt_r);
    assign tmr_busy_s    = (tmr_r != TMR_ZERO);

    // Init sequence legality: gap timing is judged first, then whether the
    // command is allowed in the current init step.
    always_comb begin
        state_leg_s = state_r;
        viol_s      = ERR_NONE;
        ref_inc_s   = 1'b0;
        mode_cap_s  = 1'b0;
        done_set_s  = 1'b0;
        if (!is_nop_s && tmr_busy_s) begin
            viol_s = tmr_code_r;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    if (!is_nop_s) begin
                        viol_s = ERR_EARLY;
                    end else if (nop_cnt_inc_s >= INIT_NOP_LIM) begin
                        state_leg_s = ST_WAIT_PRE;
                    end else begin
                        state_leg_s = ST_PWRUP;
                    end
                end
                ST_WAIT_PRE: begin
                    if ((cmd_s == CMD_PRE) && sdr_addr[10]) begin
                        state_leg_s = ST_REFRESH;
                    end else if (!is_nop_s) begin
                        viol_s = ERR_PRE;
                    end else begin
                        state_leg_s = ST_WAIT_PRE;
                    end
                end
                ST_REFRESH: begin
                    if (cmd_s == CMD_AREF) begin
                        ref_inc_s = 1'b1;
                        if (ref_cnt_inc_s >= N_REF_LIM) begin
                            state_leg_s = ST_WAIT_MRS;
                        end else begin
                            state_leg_s = ST_REFRESH;
                        end
                    end else if (!is_nop_s) begin
                        viol_s = ERR_ORDER;
                    end else begin
                        state_leg_s = ST_REFRESH;
                    end
                end
                ST_WAIT_MRS: begin
                    if (cmd_s == CMD_AREF) begin
                        ref_inc_s = 1'b1;
                    end else if (cmd_s == CMD_MRS) begin
                        mode_cap_s = 1'b1;
                        if (MRD_SKIP) begin
                            state_leg_s = ST_DONE;
                            done_set_s  = 1'b1;
                        end else begin
                            state_leg_s = ST_MRD;
                        end
                    end else if (!is_nop_s) begin
                        viol_s = ERR_ORDER;
                    end else begin
                        state_leg_s = ST_WAIT_MRS;
                    end
                end
                ST_MRD: begin
                    // Leave on the last forbidden cycle so done shows as the window closes.
                    if (!is_nop_s) begin
                        viol_s = ERR_ORDER;
                    end else if (tmr_r <= TMR_ONE) begin
                        state_leg_s = ST_DONE;
                        done_set_s  = 1'b1;
                    end else begin
                        state_leg_s = ST_MRD;
                    end
                end
                ST_DONE:  state_leg_s = ST_DONE;
                ST_ERROR: state_leg_s = ST_ERROR;
                default:  state_leg_s = ST_ERROR;
            endcase
        end
    end

    assign state_nxt_s = (viol_s != ERR_NONE) ? ST_ERROR : state_leg_s;

    // Minimum-gap timer, re-armed by every PRE/AREF/MRS in any state.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            tmr_r      <= TMR_ZERO;
            tmr_code_r <= ERR_NONE;
        end else begin
            case (cmd_s)
                CMD_PRE: begin
                    tmr_r      <= TRP_LD;
                    tmr_code_r <= ERR_TRP;
                end
                CMD_AREF: begin
                    tmr_r      <= TRFC_LD;
                    tmr_code_r <= ERR_TRFC;
                end
                CMD_MRS: begin
                    tmr_r      <= TMRD_LD;
                    tmr_code_r <= ERR_TMRD;
                end
                default: begin
                    if (tmr_busy_s) begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
            endcase
        end
    end

    // Init state, counters and the registered report outputs.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_r     <= ST_PWRUP;
            nop_cnt_r   <= 16'd0;
            cmd_r       <= CMD_NOP;
            cmd_vld_r   <= 1'b0;
            init_done_r <= 1'b0;
            init_err_r  <= 1'b0;
            err_code_r  <= ERR_NONE;
            ref_cnt_r   <= 4'd0;
            mode_reg_r  <= {SDR_AW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            cmd_r     <= cmd_s;
            cmd_vld_r <= !is_nop_s;
            if (is_nop_s) begin
                nop_cnt_r <= nop_cnt_inc_s;
            end
            if (ref_inc_s) begin
                ref_cnt_r <= ref_cnt_inc_s;
            end
            if (mode_cap_s) begin
                mode_reg_r <= sdr_addr;
            end
            if (done_set_s) begin
                init_done_r <= 1'b1;
            end
            if (viol_s != ERR_NONE) begin
                init_err_r <= 1'b1;
                if (err_code_r == ERR_NONE) begin
                    err_code_r <= viol_s;
                end
            end
        end
    end

    assign cmd_o        = cmd_r;
    assign cmd_vld_o    = cmd_vld_r;
    assign init_state_o = state_r;
    assign init_done_o  = init_done_r;
    assign init_err_o   = init_err_r;
    assign err_code_o   = err_code_r;
    assign ref_cnt_o    = ref_cnt_r;
    assign mode_reg_o   = mode_reg_r;

endmodule

// File: tb/tb_sdr_init_cmd_monitor.sv
// Bench for sdr_init_cmd_monitor: directed init scenarios plus randomized
// init-like sequences, all checked every cycle against a cycle-indexed
// reference model of the init rules.
module tb_sdr_init_cmd_monitor;
    localparam int AW     = 13;
    localparam int BW     = 2;
    localparam int NOPC   = 8;
    localparam int P_TRP  = 3;
    localparam int P_TRFC = 7;
    localparam int P_TMRD = 2;
    localparam int NREF   = 2;

    localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3;
    localparam int C_PRE = 4, C_AREF = 5, C_MRS = 6, C_BST = 7;

    typedef logic [AW-1:0] addr_t;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b1;
    logic        cs_n  = 1'b1;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n  = 1'b1;
    addr_t       addr  = '0;
    logic [BW-1:0] ba  = '0;

    logic [2:0]  cmd_o;
    logic        cmd_vld_o;
    logic [2:0]  init_state_o;
    logic        init_done_o;
    logic        init_err_o;
    logic [2:0]  err_code_o;
    logic [3:0]  ref_cnt_o;
    addr_t       mode_reg_o;

    sdr_init_cmd_monitor #(
        .SDR_AW(AW), .SDR_BW(BW), .INIT_NOP_CYCLES(NOPC),
        .TRP(P_TRP), .TRFC(P_TRFC), .TMRD(P_TMRD), .N_REFRESH(NREF)
    ) dut (
        .sdram_clk(clk), .sdram_resetn(rstn),
        .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
        .sdr_addr(addr), .sdr_ba(ba),
        .cmd_o(cmd_o), .cmd_vld_o(cmd_vld_o), .init_state_o(init_state_o),
        .init_done_o(init_done_o), .init_err_o(init_err_o), .err_code_o(err_code_o),
        .ref_cnt_o(ref_cnt_o), .mode_reg_o(mode_reg_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, counters and the cycle index of the
    // last PRE/AREF/MRS with the gap it demands.
    int     m_phase, m_nops, m_refs, m_code, m_cmd, m_gap_req, m_gap_code;
    bit     m_done, m_err, m_vld, m_armed;
    longint m_cyc, m_last_k, m_mrs_k;
    addr_t  m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("cmd",      32'(cmd_o),        32'(m_cmd));
        check("cmd_vld",  32'(cmd_vld_o),    32'(m_vld));
        check("state",    32'(init_state_o), 32'(m_phase));
        check("done",     32'(init_done_o),  32'(m_done));
        check("err",      32'(init_err_o),   32'(m_err));
        check("err_code", 32'(err_code_o),   32'(m_code));
        check("ref_cnt",  32'(ref_cnt_o),    32'(m_refs));
        check("mode_reg", 32'(mode_reg_o),   32'(m_mode));
    endtask

    task automatic model_reset();
        m_phase = 0; m_nops = 0; m_refs = 0; m_code = 0; m_cmd = 0;
        m_gap_req = 0; m_gap_code = 0; m_done = 0; m_err = 0; m_vld = 0;
        m_armed = 0; m_cyc = 0; m_last_k = 0; m_mrs_k = 0; m_mode = '0;
    endtask

    task automatic model_step(input int c, input addr_t a);
        int v;
        v = 0;
        m_cyc++;
        m_cmd = c;
        m_vld = (c != C_NOP);
        if (c != C_NOP && m_armed && (m_cyc - m_last_k) < m_gap_req) v = m_gap_code;
        if (c == C_NOP && m_nops < 65535) m_nops++;
        if (v == 0) begin
            case (m_phase)
                0: if (c != C_NOP) v = 1; else if (m_nops >= NOPC) m_phase = 1;
                1: if (c == C_PRE && a[10]) m_phase = 2; else if (c != C_NOP) v = 2;
                2, 3: begin
                    if (c == C_AREF) begin
                        if (m_refs < 15) m_refs++;
                        if (m_refs >= NREF) m_phase = 3;
                    end else if (c == C_MRS && m_phase == 3) begin
                        m_mode  = a;
                        m_mrs_k = m_cyc;
                        if (P_TMRD <= 1) begin m_phase = 5; m_done = 1; end
                        else m_phase = 4;
                    end else if (c != C_NOP) v = 5;
                end
                4: if (c != C_NOP) v = 5;
                   else if (m_cyc - m_mrs_k >= P_TMRD - 1) begin m_phase = 5; m_done = 1; end
                default: ;
            endcase
        end
        if (v != 0) begin
            m_phase = 7;
            m_err = 1;
            if (m_code == 0) m_code = v;
        end
        if (c == C_PRE)  begin m_armed = 1; m_last_k = m_cyc; m_gap_req = P_TRP;  m_gap_code = 3; end
        if (c == C_AREF) begin m_armed = 1; m_last_k = m_cyc; m_gap_req = P_TRFC; m_gap_code = 4; end
        if (c == C_MRS)  begin m_armed = 1; m_last_k = m_cyc; m_gap_req = P_TMRD; m_gap_code = 6; end
    endtask

    // Put a command on the pins; NOP uses either deselect or the 0111 encoding.
    task automatic put(input int c, input addr_t a);
        logic [3:0] p;
        logic [2:0] r;
        r = 3'($urandom);
        case (c)
            C_ACT:   p = 4'b0011;
            C_RD:    p = 4'b0101;
            C_WR:    p = 4'b0100;
            C_PRE:   p = 4'b0010;
            C_AREF:  p = 4'b0001;
            C_MRS:   p = 4'b0000;
            C_BST:   p = 4'b0110;
            default: p = ($urandom_range(1, 0) == 1) ? 4'b0111 : {1'b1, r};
        endcase
        {cs_n, ras_n, cas_n, we_n} = p;
        addr = a;
        ba   = BW'($urandom);
    endtask

    function automatic addr_t rnd_addr();
        return addr_t'($urandom);
    endfunction

    // One sampled cycle: drive at negedge, model at posedge, check 1 time unit later.
    task automatic step(input int c, input addr_t a);
        put(c, a);
        @(posedge clk);
        model_step(c, a);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(C_NOP, rnd_addr());
    endtask

    // Called at a negedge; asserts reset mid-cycle, checks the async clear, releases at a negedge.
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        put(C_NOP, '0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic legal_prefix(input int nref);
        addr_t a;
        nops(NOPC);
        a = rnd_addr();
        a[10] = 1'b1;
        step(C_PRE, a);
        nops(P_TRP - 1);
        for (int i = 0; i < nref; i++) begin
            step(C_AREF, rnd_addr());
            nops(P_TRFC - 1);
        end
    endtask

    function automatic int rgap(input int t);
        if ($urandom_range(5, 0) == 0) return $urandom_range(t - 1, 0);
        return t - 1 + $urandom_range(2, 0);
    endfunction

    task automatic maybe_cmd(input int c, input addr_t a);
        if ($urandom_range(11, 0) == 0) step($urandom_range(7, 1), a);
        else step(c, a);
    endtask

    task automatic rand_run();
        addr_t a;
        do_reset();
        if ($urandom_range(7, 0) == 0) nops($urandom_range(NOPC - 1, 1));
        else nops(NOPC + $urandom_range(3, 0));
        a = rnd_addr();
        a[10] = ($urandom_range(7, 0) != 0);
        maybe_cmd(C_PRE, a);
        nops(rgap(P_TRP));
        for (int i = 0; i < int'($urandom_range(4, 1)); i++) begin
            maybe_cmd(C_AREF, rnd_addr());
            nops(rgap(P_TRFC));
        end
        maybe_cmd(C_MRS, rnd_addr());
        nops(rgap(P_TMRD));
        for (int i = 0; i < 12; i++) begin
            step($urandom_range(7, 1), rnd_addr());
            nops($urandom_range(8, 0));
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset values.
        do_reset();

        // Legal init with default parameters.
        legal_prefix(2);
        step(C_MRS, 13'h0033);
        check("mrs_not_done_yet", 32'(init_done_o), 32'd0);
        nops(1);
        check("legal_done",  32'(init_done_o), 32'd1);
        check("legal_refs",  32'(ref_cnt_o),   32'd2);
        check("legal_mode",  32'(mode_reg_o),  32'h33);
        check("legal_noerr", 32'(init_err_o),  32'd0);
        step(C_ACT, rnd_addr());
        step(C_RD, rnd_addr());
        step(C_BST, rnd_addr());
        check("b2b_vld", 32'(cmd_vld_o), 32'd1);
        nops(1);
        check("vld_drop", 32'(cmd_vld_o), 32'd0);

        // Early command in the power-up window.
        do_reset();
        nops(5);
        step(C_AREF, rnd_addr());
        check("early_code",  32'(err_code_o),   32'd1);
        check("early_state", 32'(init_state_o), 32'd7);
        nops(10);
        check("early_nodone", 32'(init_done_o), 32'd0);

        // tRFC violation, then a tMRD violation that must not overwrite the code.
        do_reset();
        legal_prefix(0);
        step(C_AREF, rnd_addr());
        nops(3);
        step(C_AREF, rnd_addr());
        check("trfc_code", 32'(err_code_o), 32'd4);
        nops(7);
        step(C_MRS, rnd_addr());
        step(C_ACT, rnd_addr());
        check("trfc_sticky", 32'(err_code_o), 32'd4);

        // PRE without A10 in WAIT_PRE.
        do_reset();
        nops(NOPC);
        step(C_PRE, 13'h0000);
        check("pre_a10_code", 32'(err_code_o), 32'd2);

        // ACT while waiting for MRS.
        do_reset();
        legal_prefix(2);
        step(C_ACT, rnd_addr());
        check("act_wait_mrs_code", 32'(err_code_o), 32'd5);

        // Extra refresh before MRS.
        do_reset();
        legal_prefix(3);
        step(C_MRS, rnd_addr());
        nops(1);
        check("extra_done", 32'(init_done_o), 32'd1);
        check("extra_refs", 32'(ref_cnt_o),   32'd3);

        // Reset in the middle of REFRESH, then a full legal run.
        do_reset();
        legal_prefix(1);
        do_reset();
        check("midrst_refs",  32'(ref_cnt_o),    32'd0);
        check("midrst_state", 32'(init_state_o), 32'd0);
        legal_prefix(2);
        step(C_MRS, 13'h0033);
        nops(1);
        check("after_rst_done", 32'(init_done_o), 32'd1);
        check("after_rst_refs", 32'(ref_cnt_o),   32'd2);

        // Refresh counter saturation.
        do_reset();
        legal_prefix(17);
        check("ref_sat", 32'(ref_cnt_o), 32'd15);

        // Randomized init-like sequences.
        for (int r = 0; r < 40; r++) rand_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdr_init_cmd_monitor.md
# sdr_init_cmd_monitor

Passive SDRAM command-bus monitor in the `sdr_ctrl` verification environment. It samples the SDRAM control pins driven by the controller and decodes each cycle into a command. It tracks the JEDEC power-up initialisation sequence (NOP window, precharge-all, auto-refreshes, mode-register set) and checks its minimum timings. It feeds the whitebox assertion module with decoded commands, init progress, captured mode register and a sticky error code; it never drives the DUT.

## Interface
- `SDR_AW`, 13, SDRAM address width
- `SDR_BW`, 2, bank address width
- `INIT_NOP_CYCLES`, 8, minimum NOP/deselect cycles after reset before the first non-NOP command
- `TRP`, 3, minimum cycles from PRE to the next non-NOP command
- `TRFC`, 7, minimum cycles from AREF to the next non-NOP command
- `TMRD`, 2, minimum cycles from MRS to the next non-NOP command
- `N_REFRESH`, 2, auto-refresh commands required before MRS (1..15)

Ports:
- `sdram_clk` in 1: SDRAM clock; all sampling is on the rising edge
- `sdram_resetn` in 1: asynchronous active-low reset
- `sdr_cs_n`, `sdr_ras_n`, `sdr_cas_n`, `sdr_we_n` in 1 each: SDRAM command pins
- `sdr_addr` in `SDR_AW`: SDRAM address (A10 = all-banks flag)
- `sdr_ba` in `SDR_BW`: bank address
- `cmd_o` out 3: decoded command: 0 NOP/DESEL, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 AREF, 6 MRS, 7 BST
- `cmd_vld_o` out 1: one-cycle pulse for any non-NOP command
- `init_state_o` out 3: current init state encoding
- `init_done_o` out 1: init sequence completed legally (sticky)
- `init_err_o` out 1: init or timing violation (sticky)
- `err_code_o` out 3: first violation code
- `ref_cnt_o` out 4: AREF commands seen during init, saturating at 15
- `mode_reg_o` out `SDR_AW`: `sdr_addr` captured on the MRS

## Operation
- Decode {cs_n,ras_n,cas_n,we_n}:
  - cs_n=1 or 0111 → NOP
  - 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 AREF, 0000 MRS, 0110 BST
- Init states:
  - 0 PWRUP: counts NOP cycles in a 16-bit saturating counter; count reaching `INIT_NOP_CYCLES` → 1 WAIT_PRE; any non-NOP before that → error 1
  - 1 WAIT_PRE: NOP stays; PRE with A10=1 → 2 REFRESH, arm tRP timer; PRE with A10=0 or any other command → error 2
  - 2 REFRESH: NOP stays; AREF → increment `ref_cnt_o`, arm tRFC timer; after the `N_REFRESH`-th AREF → 3 WAIT_MRS; any other command → error 5
  - 3 WAIT_MRS: NOP stays; extra AREF is allowed (counted, tRFC checked); MRS → capture `sdr_addr` into `mode_reg_o`, arm tMRD timer, go to 4 MRD; any other command → error 5
  - 4 MRD: when the tMRD window is satisfied → 5 DONE, set `init_done_o`
  - 5 DONE: only command decode continues; timing timers stay active for PRE/AREF/MRS
  - 7 ERROR: sticky until reset; decode continues
- Timing timers:
  - A non-NOP command at cycle j after a PRE/AREF/MRS at cycle k requires j−k ≥ TRP/TRFC/TMRD respectively
  - Violations give error 3 (tRP), 4 (tRFC), 6 (tMRD)
  - Timing is checked before the state-legality check
- `err_code_o` latches only the first error; later violations are ignored.

## Timing
- Inputs are sampled at `sdram_clk` posedge k; all outputs are registered and reflect cycle-k input after posedge k (1-cycle latency).
- `cmd_vld_o` is high for exactly one cycle per non-NOP sample. Back-to-back commands give back-to-back pulses.
- `init_done_o` rises in the cycle the MRD window ends (MRS at k → done visible after posedge k+TMRD−1). If a command arrives earlier, error 6 is flagged instead.
- When `init_err_o` and the ERROR state are set on the same edge, `init_done_o` stays 0.
- Reset values: `cmd_o`=0, `cmd_vld_o`=0, `init_state_o`=0, `init_done_o`=0, `init_err_o`=0, `err_code_o`=0, `ref_cnt_o`=0, `mode_reg_o`=0, all timers idle.
- Reset asserted mid-sequence clears everything asynchronously; after release the monitor restarts in PWRUP with the NOP count at 0.
- The NOP counter saturates at 0xFFFF; no wrap.

## Test plan
- Legal init (defaults): 8 NOPs, PRE A10=1, 3 NOPs-equivalent spacing, AREF, 7-cycle gap, AREF, 7-cycle gap, MRS addr=0x033, 2-cycle gap → `init_done_o`=1, `ref_cnt_o`=2, `mode_reg_o`=0x033, `init_err_o`=0.
- Early command: AREF after 5 NOPs → `init_err_o`=1, `err_code_o`=1, state 7, `init_done_o` never rises.
- tRFC violation: second AREF 4 cycles after the first → `err_code_o`=4. A further tMRD violation leaves `err_code_o` at 4.
- PRE with A10=0 in WAIT_PRE → `err_code_o`=2. ACT in WAIT_MRS on a separate run → `err_code_o`=5.
- Extra refresh: 3 AREFs with legal spacing, then MRS → `init_done_o`=1, `ref_cnt_o`=3.
- Reset mid-REFRESH (after 1 AREF): all outputs return to 0 immediately. A full legal sequence afterwards completes with `ref_cnt_o`=2.
